seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, consecutive identical samples required to capture one digit; legal range 2..255.
REQ-002 Port: clk  in  1  single clock; all logic updates on the rising edge.
REQ-003 Port: rst  in  1  reset, synchronous and active-high.
REQ-004 Port: seg_n  in  7  active-low segments of a multiplexed display bus; bit0 = a ... bit6 = g; 0 = lit.
REQ-005 Port: dig_n  in  4  active-low digit select; dig_n[i]=0 selects digit i.
REQ-006 Port: value  out  16  last complete frame; digit i occupies value[4i+3:4i].
REQ-007 Port: blank_mask  out  4  bit i=1 if digit i was blank (seg_n=7'h7F) in the last frame; that nibble reads 0.
REQ-008 Port: frame_stb  out  1  one-cycle pulse when value/blank_mask update.
REQ-009 Port: err_stb  out  1  one-cycle pulse when a stable, undecodable pattern is seen.
REQ-010 Port: err_digit  out  2  index of the digit that caused the most recent err_stb.

Function
REQ-011 The decode table (seg_n to nibble) SHALL be: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F (hex); 7F = blank; any other value is invalid.
REQ-012 A sample SHALL be valid-select only when exactly one dig_n bit is 0; zero or multiple low bits mean no selection.
REQ-013 FSM states SHALL be IDLE, TRACK, HOLD.
REQ-014 IDLE: on a valid-select sample -> TRACK, stability counter = 1, reference (digit, seg_n) latched.
REQ-015 TRACK: sample equal to reference -> counter+1; when counter reaches STABLE_CYCLES the digit is processed at that edge -> HOLD.
REQ-016 TRACK: differing sample with valid select -> stay in TRACK, new reference, counter = 1; no-selection sample -> IDLE, counter = 0.
REQ-017 HOLD: while samples equal the reference, no further processing occurs (one capture per dwell); differing valid-select sample -> TRACK with counter = 1; no-selection sample -> IDLE.
REQ-018 Latency: a sample presented unchanged from edge k SHALL be processed at edge k+STABLE_CYCLES-1.
REQ-019 Processing a decodable or blank pattern SHALL write the nibble/blank bit into a shadow frame register and set bit i of a 4-bit captured mask.
REQ-020 Processing an invalid pattern SHALL pulse err_stb in the next cycle, load err_digit=i, and leave the shadow frame and captured mask unchanged.
REQ-021 Re-capturing an already-captured digit before frame completion SHALL overwrite its shadow nibble (latest wins).
REQ-022 When the captured mask becomes 4'b1111, the same edge SHALL copy shadow to value/blank_mask, assert frame_stb for exactly one cycle, and clear the captured mask.
REQ-023 frame_stb and err_stb SHALL never be high simultaneously for the same processing event; both are registered outputs.
REQ-024 The stability counter SHALL saturate at STABLE_CYCLES and never wrap.

Reset
REQ-025 With rst=1 at an edge: state=IDLE, counter=0, captured mask=0, shadow=0, value=16'h0000, blank_mask=4'b0000, frame_stb=0, err_stb=0, err_digit=0.
REQ-026 Reset mid-TRACK or mid-frame SHALL discard partial captures; no frame_stb or err_stb pulses in the cycle after the reset edge.
REQ-027 After rst deasserts, the first sample SHALL be evaluated at the next edge as from IDLE.

Verification
REQ-028 STABLE=4; scan digits 0..3 with seg_n 7'h79,24,30,19, 6 cycles each -> one frame_stb, value=16'h4321, blank_mask=0.
REQ-029 Digit 2 presented 3 cycles then changes (STABLE=4) -> no capture for digit 2; no frame_stb until digit 2 dwells >= 4 cycles.
REQ-030 Digit 1 with seg_n=7'h55 held 8 cycles -> exactly one err_stb, err_digit=1; value unchanged; frame not completed by digit 1.
REQ-031 dig_n=4'b1100 with valid pattern held 10 cycles -> no capture, no strobes.
REQ-032 Digits 0..2 captured, rst pulsed 1 cycle, then digit 3 captured -> no frame_stb; value stays 16'h0000.
REQ-033 Frame with digit 3 = 7'h7F and digits 0..2 = 7'h0E,06,21 -> value=16'h0DEF, blank_mask=4'b1000.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers digit values from a multiplexed active-low 7-segment scan bus
// Each digit is captured once per stable dwell; a full frame is published when all four are seen.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  dig_n,
  output logic [15:0] value,
  output logic [3:0]  blank_mask,
  output logic        frame_stb,
  output logic        err_stb,
  output logic [1:0]  err_digit
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  ref_dig_q, ref_dig_d;
  logic [6:0]  ref_seg_q, ref_seg_d;
  logic [3:0]  cap_q, cap_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  shblank_q, shblank_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  blank_q, blank_d;
  logic        frame_q, frame_d;
  logic        err_q, err_d;
  logic [1:0]  err_dig_q, err_dig_d;

  logic        sel_valid;
  logic [1:0]  sel_idx;
  logic        match;
  logic        process;
  logic        dec_ok;
  logic        dec_blank;
  logic [3:0]  dec_nib;
  logic [3:0]  cap_nxt;

  always_comb begin
    sel_valid = 1'b1;
    sel_idx   = 2'd0;
    case (dig_n)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_valid = 1'b0;
    endcase
  end

  assign match = (sel_idx == ref_dig_q) && (seg_n == ref_seg_q);

  always_comb begin
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    dec_nib   = 4'h0;
    case (seg_n)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      7'h7F: dec_blank = 1'b1;
      default: dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_dig_d = ref_dig_q;
    ref_seg_d = ref_seg_q;
    cap_d     = cap_q;
    shadow_d  = shadow_q;
    shblank_d = shblank_q;
    value_d   = value_q;
    blank_d   = blank_q;
    frame_d   = 1'b0;
    err_d     = 1'b0;
    err_dig_d = err_dig_q;
    process   = 1'b0;
    cap_nxt   = cap_q;

    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d   = TRACK;
          cnt_d     = 8'd1;
          ref_dig_d = sel_idx;
          ref_seg_d = seg_n;
        end else begin
          cnt_d = 8'd0;
        end
      end
      TRACK: begin
        if (!sel_valid) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (match) begin
          // Saturating count; reaching the threshold captures exactly once.
          if (cnt_q + 8'd1 >= STABLE) begin
            cnt_d   = STABLE;
            state_d = HOLD;
            process = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          cnt_d     = 8'd1;
          ref_dig_d = sel_idx;
          ref_seg_d = seg_n;
        end
      end
      HOLD: begin
        if (!sel_valid) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (!match) begin
          state_d   = TRACK;
          cnt_d     = 8'd1;
          ref_dig_d = sel_idx;
          ref_seg_d = seg_n;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    if (process) begin
      if (dec_ok) begin
        shadow_d[4*sel_idx +: 4] = dec_nib;
        shblank_d[sel_idx]       = dec_blank;
        cap_nxt                  = cap_q | (4'b0001 << sel_idx);
        if (cap_nxt == 4'b1111) begin
          value_d = shadow_d;
          blank_d = shblank_d;
          frame_d = 1'b1;
          cap_d   = 4'b0000;
        end else begin
          cap_d = cap_nxt;
        end
      end else begin
        err_d     = 1'b1;
        err_dig_d = sel_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      ref_dig_q <= 2'd0;
      ref_seg_q <= 7'h00;
      cap_q     <= 4'b0000;
      shadow_q  <= 16'h0000;
      shblank_q <= 4'b0000;
      value_q   <= 16'h0000;
      blank_q   <= 4'b0000;
      frame_q   <= 1'b0;
      err_q     <= 1'b0;
      err_dig_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_dig_q <= ref_dig_d;
      ref_seg_q <= ref_seg_d;
      cap_q     <= cap_d;
      shadow_q  <= shadow_d;
      shblank_q <= shblank_d;
      value_q   <= value_d;
      blank_q   <= blank_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
      err_dig_q <= err_dig_d;
    end
  end

  assign value      = value_q;
  assign blank_mask = blank_q;
  assign frame_stb  = frame_q;
  assign err_stb    = err_q;
  assign err_digit  = err_dig_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - random and directed checks of seg_scan_decoder against a dwell-length model
module tb_seg_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic        frame_stb;
  logic        err_stb;
  logic [1:0]  err_digit;

  seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_n     (seg_n),
    .dig_n     (dig_n),
    .value     (value),
    .blank_mask(blank_mask),
    .frame_stb (frame_stb),
    .err_stb   (err_stb),
    .err_digit (err_digit)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference: a capture happens when an unbroken run of identical selected samples reaches length S.
  int          run;
  int          pdig;
  logic [6:0]  pseg;
  logic [15:0] m_shadow, m_value;
  logic [3:0]  m_sblank, m_blank, m_cap;
  logic        m_frame, m_err;
  logic [1:0]  m_errdig;
  int          obs_frames, obs_errs;

  function automatic int decode(input logic [6:0] s);
    if (s == 7'h7F) return 16;
    for (int i = 0; i < 16; i++) if (codes[i] == s) return i;
    return -1;
  endfunction

  task automatic model_edge(input logic r, input logic [3:0] d, input logic [6:0] s);
    int lows, idx, dv;
    m_frame = 1'b0;
    m_err   = 1'b0;
    if (r) begin
      run = 0; m_shadow = '0; m_value = '0; m_sblank = '0; m_blank = '0;
      m_cap = '0; m_errdig = '0;
      return;
    end
    lows = 0; idx = 0;
    for (int i = 0; i < 4; i++) if (!d[i]) begin lows++; idx = i; end
    if (lows != 1) begin
      run = 0;
      return;
    end
    if (run > 0 && idx == pdig && s == pseg) run++;
    else begin run = 1; pdig = idx; pseg = s; end
    if (run == S) begin
      dv = decode(s);
      if (dv < 0) begin
        m_err = 1'b1;
        m_errdig = 2'(idx);
      end else begin
        m_shadow[idx*4 +: 4] = (dv == 16) ? 4'h0 : 4'(dv);
        m_sblank[idx]        = (dv == 16);
        m_cap[idx]           = 1'b1;
        if (m_cap == 4'hF) begin
          m_value = m_shadow;
          m_blank = m_sblank;
          m_frame = 1'b1;
          m_cap   = 4'h0;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] d, input logic [6:0] s);
    rst = r; dig_n = d; seg_n = s;
    @(posedge clk);
    model_edge(r, d, s);
    @(negedge clk);
    if (frame_stb) obs_frames++;
    if (err_stb) obs_errs++;
    check_eq("value", 32'(value), 32'(m_value));
    check_eq("blank_mask", 32'(blank_mask), 32'(m_blank));
    check_eq("frame_stb", 32'(frame_stb), 32'(m_frame));
    check_eq("err_stb", 32'(err_stb), 32'(m_err));
    check_eq("err_digit", 32'(err_digit), 32'(m_errdig));
  endtask

  task automatic dwell(input int dig, input logic [6:0] s, input int n);
    for (int k = 0; k < n; k++) step(1'b0, ~(4'b0001 << dig), s);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 4'hF, 7'h7F);
  endtask

  initial begin
    rst = 1'b1; dig_n = 4'hF; seg_n = 7'h7F; run = 0; pdig = 0; pseg = '0;
    m_frame = 0; m_err = 0;
    @(negedge clk);
    step(1'b1, 4'hF, 7'h7F);
    step(1'b1, 4'hF, 7'h7F);
    check_eq("reset_value", 32'(value), 32'h0);

    obs_frames = 0; obs_errs = 0;
    dwell(0, 7'h79, 6); dwell(1, 7'h24, 6); dwell(2, 7'h30, 6); dwell(3, 7'h19, 6);
    idle(2);
    check_eq("scan_frames", 32'(obs_frames), 32'd1);
    check_eq("scan_value", 32'(value), 32'h4321);
    check_eq("scan_blank", 32'(blank_mask), 32'h0);

    obs_frames = 0;
    dwell(0, 7'h40, 6); dwell(1, 7'h79, 6); dwell(2, 7'h24, 3); dwell(3, 7'h30, 6);
    idle(2);
    check_eq("short_dwell_frames", 32'(obs_frames), 32'd0);
    dwell(2, 7'h24, 6);
    idle(2);
    check_eq("late_digit2_frames", 32'(obs_frames), 32'd1);
    check_eq("late_digit2_value", 32'(value), 32'h3210);

    obs_frames = 0; obs_errs = 0;
    dwell(1, 7'h55, 8);
    idle(2);
    check_eq("bad_pattern_errs", 32'(obs_errs), 32'd1);
    check_eq("bad_pattern_digit", 32'(err_digit), 32'd1);
    check_eq("bad_pattern_value", 32'(value), 32'h3210);
    dwell(0, 7'h40, 5); dwell(2, 7'h40, 5); dwell(3, 7'h40, 5);
    idle(1);
    check_eq("bad_digit_no_frame", 32'(obs_frames), 32'd0);

    obs_frames = 0; obs_errs = 0;
    for (int k = 0; k < 10; k++) step(1'b0, 4'b1100, 7'h79);
    check_eq("multi_sel_strobes", 32'(obs_frames + obs_errs), 32'd0);

    step(1'b1, 4'hF, 7'h7F);
    obs_frames = 0;
    dwell(0, 7'h79, 5); dwell(1, 7'h79, 5); dwell(2, 7'h79, 5);
    step(1'b1, 4'hF, 7'h7F);
    dwell(3, 7'h79, 6);
    idle(2);
    check_eq("reset_drop_frames", 32'(obs_frames), 32'd0);
    check_eq("reset_drop_value", 32'(value), 32'h0);

    step(1'b1, 4'hF, 7'h7F);
    dwell(0, 7'h0E, 4); dwell(1, 7'h06, 4); dwell(2, 7'h21, 4); dwell(3, 7'h7F, 4);
    idle(1);
    check_eq("blank_value", 32'(value), 32'h0DEF);
    check_eq("blank_mask3", 32'(blank_mask), 32'h8);

    for (int n = 0; n < 400; n++) begin
      int dsel, ssel, len;
      logic [3:0] d;
      logic [6:0] s;
      dsel = $urandom_range(0, 9);
      if (dsel < 8) d = ~(4'b0001 << (dsel % 4));
      else if (dsel == 8) d = 4'hF;
      else d = 4'($urandom);
      ssel = $urandom_range(0, 9);
      if (ssel < 7) s = codes[$urandom_range(0, 15)];
      else if (ssel == 7) s = 7'h7F;
      else s = 7'($urandom);
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) step(1'b0, d, s);
      if ($urandom_range(0, 49) == 0) step(1'b1, 4'hF, 7'h7F);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
